mc_controller: RTL and testbench

Multicycle control unit of the MIPS core. It sits directly upstream of the `alu` block. It decodes the instruction-register opcode and funct fields and steps a Moore state machine through fetch, decode, execute, memory and writeback. In each state it drives the `alu_ctrl` code consumed by `alu`, plus every datapath enable and mux select. It also samples `alu`'s `zero` flag to resolve `beq`.

---
 rtl/mc_controller_pkg.sv | 119 +++++++++++
 rtl/alu_ctrl_decoder.sv | 23 ++
 rtl/mc_controller.sv | 93 +++++++++
 tb/tb_mc_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs, ALU codes, states.
package mc_controller_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OFF = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] alu_ctrl;
    logic             pc_write;
    logic             branch;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
  } ctrl_t;

  // Moore control word for a state; exec_alu is the decoded funct used only in EXECUTE.
  function automatic ctrl_t ctrl_for_state(state_t s, logic [ALU_W-1:0] exec_alu);
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = ALU_OFF;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_ctrl  = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_ADR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = exec_alu;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.branch    = 1'b1;
        c.pc_src    = 2'b01;
        c.alu_ctrl  = ALU_SUB;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational R-type funct decode into an ALU operation plus a legality flag.
module alu_ctrl_decoder
  import mc_controller_pkg::*;
(
  input  logic [FN_W-1:0]  funct,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             funct_legal
);

  always_comb begin
    alu_ctrl    = ALU_OFF;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with registered Moore outputs.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FN_W-1:0]    funct,
  input  logic               zero,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic               pc_en,
  output logic               pc_write,
  output logic               branch,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [STATE_W-1:0] state_dbg
);

  state_t           state;
  ctrl_t            ctrl;
  logic [ALU_W-1:0] dec_alu;
  logic             dec_legal;

  alu_ctrl_decoder u_alu_ctrl_decoder (
    .funct       (funct),
    .alu_ctrl    (dec_alu),
    .funct_legal (dec_legal)
  );

  function automatic state_t next_state(state_t s, logic [OP_W-1:0] op, logic legal);
    state_t n;
    n = S_FETCH;
    case (s)
      S_IDLE: n = S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEM_ADR;
          OP_RTYPE:     n = legal ? S_EXECUTE : S_FETCH;
          OP_BEQ:       n = S_BRANCH;
          OP_ADDI:      n = S_ADDI_EX;
          OP_J:         n = S_JUMP;
          default:      n = S_FETCH;
        endcase
      end
      S_FETCH:   n = S_DECODE;
      S_MEM_ADR: n = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: n = S_MEM_WB;
      S_EXECUTE: n = S_R_WB;
      S_ADDI_EX: n = S_ADDI_WB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  // The funct decode is latched into the registered alu_ctrl on the DECODE->EXECUTE edge,
  // so later funct changes cannot disturb EXECUTE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ctrl  <= ctrl_for_state(S_IDLE, ALU_OFF);
    end else begin
      state <= next_state(state, opcode, dec_legal);
      ctrl  <= ctrl_for_state(next_state(state, opcode, dec_legal), dec_alu);
    end
  end

  assign alu_ctrl   = ctrl.alu_ctrl;
  assign pc_write   = ctrl.pc_write;
  assign branch     = ctrl.branch;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign state_dbg  = state;

  // PC load needs the live zero flag for beq, so it stays combinational.
  assign pc_en = ctrl.pc_write | (ctrl.branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: reset, each instruction class, illegal decode, funct hold.
module tb_mc_controller;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_OFF = 3'b100;
  localparam logic [2:0] A_SUB = 3'b110;

  logic       clk, rst, zero;
  logic [5:0] opcode, funct;
  logic [2:0] alu_ctrl;
  logic       pc_en, pc_write, branch, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state_dbg;

  int passed = 0;
  int total  = 0;
  int bad_wr = 0;
  logic watch_wr = 1'b0;

  mc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_ctrl(alu_ctrl), .pc_en(pc_en), .pc_write(pc_write), .branch(branch),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (watch_wr && (reg_write || mem_write)) bad_wr++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    total++; if (state_dbg !== 4'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else passed++;
    total++; if (alu_ctrl !== A_OFF) $display("FAIL reset_alu: got %b want %b", alu_ctrl, A_OFF); else passed++;
    total++; if ({pc_en, mem_read, ir_write, reg_write} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {pc_en, mem_read, ir_write, reg_write}); else passed++;
    rst = 1'b0;
    tick();
    total++; if (state_dbg !== 4'd1) $display("FAIL first_fetch_state: got %0d want 1", state_dbg); else passed++;
    total++; if ({mem_read, ir_write, pc_write, pc_en} !== 4'b1111) $display("FAIL fetch_ctrl: got %b want 1111", {mem_read, ir_write, pc_write, pc_en}); else passed++;
    total++; if ({alu_src_b, alu_ctrl} !== {2'b01, A_ADD}) $display("FAIL fetch_alu: got %b want %b", {alu_src_b, alu_ctrl}, {2'b01, A_ADD}); else passed++;
  endtask

  task automatic test_rtype_sub();
    opcode = 6'b000000; funct = 6'b100010;
    tick();
    total++; if ({state_dbg, alu_src_b, alu_ctrl} !== {4'd2, 2'b11, A_ADD}) $display("FAIL sub_decode: got %b want %b", {state_dbg, alu_src_b, alu_ctrl}, {4'd2, 2'b11, A_ADD}); else passed++;
    tick();
    total++; if (state_dbg !== 4'd7) $display("FAIL sub_exec_state: got %0d want 7", state_dbg); else passed++;
    total++; if ({alu_ctrl, alu_src_a, alu_src_b} !== {A_SUB, 1'b1, 2'b00}) $display("FAIL sub_exec_ctrl: got %b want %b", {alu_ctrl, alu_src_a, alu_src_b}, {A_SUB, 1'b1, 2'b00}); else passed++;
    tick();
    total++; if ({state_dbg, reg_write, reg_dst, mem_to_reg} !== {4'd8, 3'b110}) $display("FAIL sub_rwb: got %b want %b", {state_dbg, reg_write, reg_dst, mem_to_reg}, {4'd8, 3'b110}); else passed++;
    tick();
    total++; if ({state_dbg, reg_write} !== {4'd1, 1'b0}) $display("FAIL sub_back_fetch: got %b want %b", {state_dbg, reg_write}, {4'd1, 1'b0}); else passed++;
  endtask

  task automatic test_lw();
    opcode = 6'b100011; funct = 6'b000000;
    tick(); tick();
    total++; if ({state_dbg, alu_src_a, alu_src_b, alu_ctrl} !== {4'd3, 1'b1, 2'b10, A_ADD}) $display("FAIL lw_memadr: got %b want %b", {state_dbg, alu_src_a, alu_src_b, alu_ctrl}, {4'd3, 1'b1, 2'b10, A_ADD}); else passed++;
    tick();
    total++; if ({state_dbg, i_or_d, mem_read, ir_write} !== {4'd4, 3'b110}) $display("FAIL lw_memread: got %b want %b", {state_dbg, i_or_d, mem_read, ir_write}, {4'd4, 3'b110}); else passed++;
    tick();
    total++; if ({state_dbg, mem_to_reg, reg_write, reg_dst} !== {4'd5, 3'b110}) $display("FAIL lw_memwb: got %b want %b", {state_dbg, mem_to_reg, reg_write, reg_dst}, {4'd5, 3'b110}); else passed++;
    tick();
    total++; if (state_dbg !== 4'd1) $display("FAIL lw_back_fetch: got %0d want 1", state_dbg); else passed++;
  endtask

  task automatic test_sw();
    opcode = 6'b101011;
    tick(); tick(); tick();
    total++; if ({state_dbg, mem_write, i_or_d, mem_read} !== {4'd6, 3'b110}) $display("FAIL sw_memwrite: got %b want %b", {state_dbg, mem_write, i_or_d, mem_read}, {4'd6, 3'b110}); else passed++;
    tick();
    total++; if ({state_dbg, mem_write} !== {4'd1, 1'b0}) $display("FAIL sw_back_fetch: got %b want %b", {state_dbg, mem_write}, {4'd1, 1'b0}); else passed++;
  endtask

  task automatic test_beq();
    opcode = 6'b000100; zero = 1'b1;
    tick(); tick();
    total++; if ({state_dbg, branch, pc_src, alu_ctrl, alu_src_a} !== {4'd9, 1'b1, 2'b01, A_SUB, 1'b1}) $display("FAIL beq_branch_ctrl: got %b want %b", {state_dbg, branch, pc_src, alu_ctrl, alu_src_a}, {4'd9, 1'b1, 2'b01, A_SUB, 1'b1}); else passed++;
    total++; if (pc_en !== 1'b1) $display("FAIL beq_taken_pc_en: got %b want 1", pc_en); else passed++;
    tick();
    total++; if (state_dbg !== 4'd1) $display("FAIL beq_taken_next: got %0d want 1", state_dbg); else passed++;
    zero = 1'b0;
    tick(); tick();
    total++; if ({state_dbg, pc_en, pc_write} !== {4'd9, 2'b00}) $display("FAIL beq_not_taken: got %b want %b", {state_dbg, pc_en, pc_write}, {4'd9, 2'b00}); else passed++;
    tick();
    total++; if (state_dbg !== 4'd1) $display("FAIL beq_not_taken_next: got %0d want 1", state_dbg); else passed++;
  endtask

  task automatic test_addi_jump();
    opcode = 6'b001000;
    tick(); tick();
    total++; if ({state_dbg, alu_src_a, alu_src_b, alu_ctrl} !== {4'd10, 1'b1, 2'b10, A_ADD}) $display("FAIL addi_ex: got %b want %b", {state_dbg, alu_src_a, alu_src_b, alu_ctrl}, {4'd10, 1'b1, 2'b10, A_ADD}); else passed++;
    tick();
    total++; if ({state_dbg, reg_write, reg_dst, mem_to_reg} !== {4'd11, 3'b100}) $display("FAIL addi_wb: got %b want %b", {state_dbg, reg_write, reg_dst, mem_to_reg}, {4'd11, 3'b100}); else passed++;
    tick();
    opcode = 6'b000010;
    tick(); tick();
    total++; if ({state_dbg, pc_write, pc_src, pc_en, alu_ctrl} !== {4'd12, 1'b1, 2'b10, 1'b1, A_OFF}) $display("FAIL jump: got %b want %b", {state_dbg, pc_write, pc_src, pc_en, alu_ctrl}, {4'd12, 1'b1, 2'b10, 1'b1, A_OFF}); else passed++;
    tick();
    total++; if (state_dbg !== 4'd1) $display("FAIL jump_next: got %0d want 1", state_dbg); else passed++;
  endtask

  task automatic test_illegal();
    bad_wr = 0; watch_wr = 1'b1;
    opcode = 6'b111111;
    tick();
    total++; if (state_dbg !== 4'd2) $display("FAIL illegal_op_decode: got %0d want 2", state_dbg); else passed++;
    tick();
    total++; if (state_dbg !== 4'd1) $display("FAIL illegal_op_next: got %0d want 1", state_dbg); else passed++;
    opcode = 6'b000000; funct = 6'b000111;
    tick(); tick();
    total++; if (state_dbg !== 4'd1) $display("FAIL illegal_funct_next: got %0d want 1", state_dbg); else passed++;
    watch_wr = 1'b0;
    total++; if (bad_wr !== 0) $display("FAIL illegal_writes: got %0d want 0", bad_wr); else passed++;
  endtask

  task automatic test_funct_hold();
    opcode = 6'b000000; funct = 6'b100100;
    tick(); tick();
    total++; if ({state_dbg, alu_ctrl} !== {4'd7, A_AND}) $display("FAIL hold_exec: got %b want %b", {state_dbg, alu_ctrl}, {4'd7, A_AND}); else passed++;
    funct = 6'b101010;
    #3;
    total++; if (alu_ctrl !== A_AND) $display("FAIL hold_after_change: got %b want %b", alu_ctrl, A_AND); else passed++;
    tick();
    total++; if (state_dbg !== 4'd8) $display("FAIL hold_rwb: got %0d want 8", state_dbg); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011; funct = 6'b000000;
    tick(); tick(); tick();
    total++; if ({state_dbg, mem_read} !== {4'd4, 1'b1}) $display("FAIL mid_pre_reset: got %b want %b", {state_dbg, mem_read}, {4'd4, 1'b1}); else passed++;
    rst = 1'b1;
    #1;
    total++; if ({state_dbg, mem_read, i_or_d, alu_ctrl} !== {4'd0, 2'b00, A_OFF}) $display("FAIL mid_reset_async: got %b want %b", {state_dbg, mem_read, i_or_d, alu_ctrl}, {4'd0, 2'b00, A_OFF}); else passed++;
    tick();
    total++; if ({state_dbg, reg_write} !== {4'd0, 1'b0}) $display("FAIL mid_reset_hold: got %b want %b", {state_dbg, reg_write}, {4'd0, 1'b0}); else passed++;
    rst = 1'b0;
    tick();
    total++; if (state_dbg !== 4'd1) $display("FAIL mid_release_fetch: got %0d want 1", state_dbg); else passed++;
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; opcode = 6'b0; funct = 6'b0;
    test_reset();
    test_rtype_sub();
    test_lw();
    test_sw();
    test_beq();
    test_addi_jump();
    test_illegal();
    test_funct_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
